// File: rtl/mux_nx1_scan_if.sv
// Bus bundle for mux_nx1_scan: parallel channel inputs, select controls and
// the registered output handshake. Optional out_parity exists only when
// PARITY_EN is defined.
interface mux_nx1_scan_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
);
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic                     mode;
    logic [SEL_W-1:0]         sel_in;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic [SEL_W-1:0]         out_ch;
    logic                     sel_err;
    logic                     scan_wrap;
`ifdef PARITY_EN
    logic                     out_parity;

    modport master (
        output ch_data, ch_valid, mode, sel_in, out_ready,
        input  out_data, out_valid, out_ch, sel_err, scan_wrap, out_parity
    );
    modport slave (
        input  ch_data, ch_valid, mode, sel_in, out_ready,
        output out_data, out_valid, out_ch, sel_err, scan_wrap, out_parity
    );
`else
    modport master (
        output ch_data, ch_valid, mode, sel_in, out_ready,
        input  out_data, out_valid, out_ch, sel_err, scan_wrap
    );
    modport slave (
        input  ch_data, ch_valid, mode, sel_in, out_ready,
        output out_data, out_valid, out_ch, sel_err, scan_wrap
    );
`endif
endinterface

// File: rtl/mux_nx1_scan.sv
// N:1 W-bit multiplexer with a registered output and valid/ready handshake.
// MANUAL mode selects via sel_in; SCAN mode walks a round-robin pointer.
// Optional feature macro: PARITY_EN adds out_parity = ^out_data (registered).
module mux_nx1_scan #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic           clk,
    input  logic           rst,
    mux_nx1_scan_if.slave  bus
);
    typedef enum logic {
        S_MAN  = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;
    logic               sel_err_q, sel_err_d;
    logic               scan_wrap_q, scan_wrap_d;
`ifdef PARITY_EN
    logic               out_parity_q, out_parity_d;
`endif

    logic [SEL_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  pick_data;
    logic               pick_vld;
    logic               sel_ok;
    logic               ptr_last;
    logic               slot_free;
    logic               capture;

    // Channel lookup for the index in use this cycle (sel_in or scan pointer)
    always_comb begin
        pick_idx  = (state_q == S_SCAN) ? ptr_q : bus.sel_in;
        pick_data = '0;
        pick_vld  = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (pick_idx == SEL_W'(k)) begin
                pick_data = bus.ch_data[k*DATA_W +: DATA_W];
                pick_vld  = bus.ch_valid[k];
            end
        end
        sel_ok    = 32'(bus.sel_in) < 32'(NUM_CH);
        ptr_last  = (ptr_q == SEL_W'(NUM_CH - 1));
        slot_free = !out_valid_q || bus.out_ready;
    end

    // Next-state: mode tracking, pointer walk, capture/transfer and pulses
    always_comb begin
        state_d     = bus.mode ? S_SCAN : S_MAN;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        sel_err_d   = 1'b0;
        scan_wrap_d = 1'b0;
        capture     = 1'b0;
`ifdef PARITY_EN
        out_parity_d = out_parity_q;
`endif
        if (slot_free) begin
            case (state_q)
                S_MAN: begin
                    if (!sel_ok) sel_err_d = 1'b1;
                    else         capture   = pick_vld;
                end
                S_SCAN: begin
                    capture     = pick_vld;
                    scan_wrap_d = ptr_last;
                    ptr_d       = ptr_last ? '0 : ptr_q + SEL_W'(1);
                end
                default: ;
            endcase
        end
        // Entering SCAN always restarts at ch0; a stall cannot delay this
        if (state_q == S_MAN && bus.mode) ptr_d = '0;
        if (capture) begin
            out_data_d  = pick_data;
            out_ch_d    = pick_idx;
            out_valid_d = 1'b1;
`ifdef PARITY_EN
            out_parity_d = ^pick_data;
`endif
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_MAN;
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            sel_err_q   <= 1'b0;
            scan_wrap_q <= 1'b0;
`ifdef PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            sel_err_q   <= sel_err_d;
            scan_wrap_q <= scan_wrap_d;
`ifdef PARITY_EN
            out_parity_q <= out_parity_d;
`endif
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.scan_wrap = scan_wrap_q;
`ifdef PARITY_EN
    assign bus.out_parity = out_parity_q;
`endif
endmodule

// File: tb/tb_mux_nx1_scan.sv
// Bench for mux_nx1_scan: an 8-channel and a 6-channel instance share one
// stimulus stream; a behavioural model checks both every cycle, and directed
// literal expectations pin key points of the behaviour.
module tb_mux_nx1_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] ch_data = '0;
    logic [7:0]  ch_valid = '0;
    logic        mode = 1'b0;
    logic [2:0]  sel_in = '0;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_nx1_scan_if #(.NUM_CH(8), .DATA_W(8)) ia ();
    mux_nx1_scan_if #(.NUM_CH(6), .DATA_W(8)) ib ();

    assign ia.ch_data   = ch_data;
    assign ia.ch_valid  = ch_valid;
    assign ia.mode      = mode;
    assign ia.sel_in    = sel_in;
    assign ia.out_ready = out_ready;
    assign ib.ch_data   = ch_data[47:0];
    assign ib.ch_valid  = ch_valid[5:0];
    assign ib.mode      = mode;
    assign ib.sel_in    = sel_in;
    assign ib.out_ready = out_ready;

    mux_nx1_scan #(.NUM_CH(8), .DATA_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    mux_nx1_scan #(.NUM_CH(6), .DATA_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model, index 0 = 8-channel instance, 1 = 6-channel instance
    bit         m_valid[2] = '{0, 0};
    logic [7:0] m_data[2]  = '{8'h00, 8'h00};
    int         m_ch[2]    = '{0, 0};
    int         m_ptr[2]   = '{0, 0};
    bit         m_scan[2]  = '{0, 0};
    bit         m_err[2]   = '{0, 0};
    bit         m_wrap[2]  = '{0, 0};

    task automatic model_step(input int i, input int n);
        bit free, xfer, cap, err, wrap;
        int idx, nptr;
        if (rst) begin
            m_valid[i] = 0; m_data[i] = 8'h00; m_ch[i] = 0; m_ptr[i] = 0;
            m_scan[i] = 0; m_err[i] = 0; m_wrap[i] = 0;
            return;
        end
        free = !m_valid[i] || out_ready;
        xfer = m_valid[i] && out_ready;
        cap = 0; err = 0; wrap = 0; idx = 0; nptr = m_ptr[i];
        if (free) begin
            if (!m_scan[i]) begin
                if (int'(sel_in) >= n) err = 1;
                else if (ch_valid[sel_in]) begin cap = 1; idx = int'(sel_in); end
            end else begin
                idx  = m_ptr[i];
                cap  = ch_valid[idx];
                wrap = (m_ptr[i] == n - 1);
                nptr = (m_ptr[i] + 1) % n;
            end
        end
        if (!m_scan[i] && mode) nptr = 0;
        m_scan[i] = mode;
        m_ptr[i]  = nptr;
        m_err[i]  = err;
        m_wrap[i] = wrap;
        if (cap) begin
            m_valid[i] = 1; m_data[i] = ch_data[idx*8 +: 8]; m_ch[i] = idx;
        end else if (xfer) begin
            m_valid[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 8);
        model_step(1, 6);
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("a_valid", ia.out_valid, m_valid[0]);
        chk("a_sel_err", ia.sel_err, m_err[0]);
        chk("a_scan_wrap", ia.scan_wrap, m_wrap[0]);
        chk("b_valid", ib.out_valid, m_valid[1]);
        chk("b_sel_err", ib.sel_err, m_err[1]);
        chk("b_scan_wrap", ib.scan_wrap, m_wrap[1]);
        if (m_valid[0]) begin
            chk("a_data", ia.out_data, m_data[0]);
            chk("a_ch", ia.out_ch, m_ch[0]);
`ifdef PARITY_EN
            chk("a_parity", ia.out_parity, ^m_data[0]);
`endif
        end
        if (m_valid[1]) begin
            chk("b_data", ib.out_data, m_data[1]);
            chk("b_ch", ib.out_ch, m_ch[1]);
`ifdef PARITY_EN
            chk("b_parity", ib.out_parity, ^m_data[1]);
`endif
        end
    end

    logic [7:0] exp_d[4] = '{8'h00, 8'h22, 8'h55, 8'h77};
    int         exp_c[4] = '{0, 2, 5, 7};
    logic [7:0] got_d[$];
    int         got_c[$];
    int         wraps[$];

    initial begin
        // Reset with random inputs for two clocks
        ch_data   = {$urandom, $urandom};
        ch_valid  = 8'($urandom);
        mode      = 1'($urandom);
        sel_in    = 3'($urandom);
        out_ready = 1'($urandom);
        repeat (2) @(negedge clk);
        chk("rst_valid", ia.out_valid, 0);
        chk("rst_data", ia.out_data, 0);
        chk("rst_ch", ia.out_ch, 0);
        chk("rst_sel_err", ia.sel_err, 0);
        chk("rst_scan_wrap", ia.scan_wrap, 0);
`ifdef PARITY_EN
        chk("rst_parity", ia.out_parity, 0);
`endif

        // First post-reset cycle evaluates as MANUAL even with mode=1
        rst = 1'b0; mode = 1'b1; sel_in = 3'd3; ch_valid = 8'h08;
        ch_data = '0; ch_data[3*8 +: 8] = 8'hA5; out_ready = 1'b1;
        @(negedge clk);
        chk("first_manual_valid", ia.out_valid, 1);
        chk("first_manual_data", ia.out_data, 8'hA5);
        chk("first_manual_ch", ia.out_ch, 3);

        // MANUAL capture
        mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("manual_valid", ia.out_valid, 1);
        chk("manual_data", ia.out_data, 8'hA5);
        chk("manual_ch", ia.out_ch, 3);

        // Back-pressure holds A5, release captures 5A
        out_ready = 1'b0; ch_data[3*8 +: 8] = 8'h5A;
        repeat (4) begin
            @(negedge clk);
            chk("stall_data", ia.out_data, 8'hA5);
            chk("stall_valid", ia.out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_data", ia.out_data, 8'h5A);
        chk("release_valid", ia.out_valid, 1);

        // SCAN over ch_valid=1010_0101, chK = K*0x11
        mode = 1'b1; ch_valid = 8'hA5;
        for (int k = 0; k < 8; k++) ch_data[k*8 +: 8] = 8'(k * 8'h11);
        @(negedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (ia.out_valid) begin got_d.push_back(ia.out_data); got_c.push_back(int'(ia.out_ch)); end
            if (ia.scan_wrap) wraps.push_back(c);
        end
        chk("scan_count", got_d.size(), 8);
        for (int k = 0; k < 4; k++) begin
            if (k < got_d.size()) begin
                chk($sformatf("scan_data%0d", k), got_d[k], exp_d[k]);
                chk($sformatf("scan_ch%0d", k), got_c[k], exp_c[k]);
            end
        end
        chk("wrap_count", wraps.size(), 2);
        if (wraps.size() == 2) chk("wrap_period", wraps[1] - wraps[0], 8);

        // Out-of-range select on the 6-channel instance
        mode = 1'b0; sel_in = 3'd7; ch_valid = 8'hFF;
        repeat (2) @(negedge clk);
        chk("b_sel_err_pulse", ib.sel_err, 1);
        chk("b_no_valid", ib.out_valid, 0);
        chk("a_sel7_no_err", ia.sel_err, 0);
        sel_in = 3'd1; ch_valid = 8'h00;
        @(negedge clk);
        chk("b_sel_err_clear", ib.sel_err, 0);

        // Mode switch during a stall keeps the item; scan restarts at ch0
        sel_in = 3'd3; ch_valid = 8'hFF;
        @(negedge clk);
        chk("pre_switch_data", ia.out_data, 8'h33);
        out_ready = 1'b0;
        @(negedge clk);
        mode = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("switch_hold_data", ia.out_data, 8'h33);
            chk("switch_hold_ch", ia.out_ch, 3);
            chk("switch_hold_valid", ia.out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("scan_restart_data", ia.out_data, 8'h00);
        chk("scan_restart_ch", ia.out_ch, 0);
        @(negedge clk);
        chk("scan_next_data", ia.out_data, 8'h11);
        chk("scan_next_ch", ia.out_ch, 1);

        // Parity values
        mode = 1'b0; sel_in = 3'd1; ch_valid = 8'h02; ch_data[1*8 +: 8] = 8'h07;
        repeat (2) @(negedge clk);
        chk("par7_data", ia.out_data, 8'h07);
`ifdef PARITY_EN
        chk("par7_parity", ia.out_parity, 1);
`endif
        ch_data[1*8 +: 8] = 8'h03;
        @(negedge clk);
        chk("par3_data", ia.out_data, 8'h03);
`ifdef PARITY_EN
        chk("par3_parity", ia.out_parity, 0);
`endif

        // Reset mid-transfer drops the held item
        out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", ia.out_valid, 0);
        chk("midrst_data", ia.out_data, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
